// File: rtl/prog_seq_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Holds the state encoding, the length-field width and the pattern mask builder.
package prog_seq_pkg;

  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_CFG_ERR = 1'b1
  } state_t;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Low 'len' bits set; callers slice down to their pattern width.
  function automatic logic [31:0] len_mask(input int unsigned len);
    if (len >= 32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   r_q <= '0;
    else if (i_clr)              r_q <= '0;
    else if (i_inc && r_q != '1) r_q <= r_q + W'(1);
  end

  assign o_q = r_q;

endmodule

// File: rtl/prog_seq_detector.sv
// Runtime-programmable serial bit-sequence detector with qualified input stream,
// registered one-cycle match pulse and saturating match counter.
module prog_seq_detector
  import prog_seq_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1011),
  parameter int                 DEF_LEN     = 4,
  parameter logic               DEF_OVERLAP = 1'b1,
  localparam int                LEN_W       = len_width(MAX_LEN)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_din_valid,
  input  logic               i_din,
  output logic               o_dout,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_armed,
  output logic               o_cfg_err
);

  state_t             r_state, w_state_nxt;
  logic [MAX_LEN-1:0] r_pat, w_pat_nxt;
  logic [MAX_LEN-1:0] r_hist, w_hist_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [LEN_W-1:0]   r_fill, w_fill_nxt;
  logic               r_ovl, w_ovl_nxt;
  logic               r_dout;

  logic [MAX_LEN-1:0] w_window;
  logic [31:0]        w_mask_full;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fill_p1;
  logic               w_cfg_ok;
  logic               w_match;

  // Window of the most recent bits including the one on the wire this cycle.
  assign w_window    = {r_hist[MAX_LEN-2:0], i_din};
  assign w_mask_full = len_mask(32'(r_len));
  assign w_mask      = w_mask_full[MAX_LEN-1:0];
  assign w_fill_p1   = {1'b0, r_fill} + (LEN_W+1)'(1);
  assign w_cfg_ok    = (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAX_LEN));

  assign w_match = (r_state == ST_ARMED) && i_din_valid && !i_cfg_load
                && (w_fill_p1 >= {1'b0, r_len})
                && ((w_window & w_mask) == (r_pat & w_mask));

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_len_nxt   = r_len;
    w_ovl_nxt   = r_ovl;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    if (i_cfg_load) begin
      w_hist_nxt = '0;
      w_fill_nxt = '0;
      if (w_cfg_ok) begin
        w_state_nxt = ST_ARMED;
        w_pat_nxt   = i_cfg_pattern;
        w_len_nxt   = i_cfg_len;
        w_ovl_nxt   = i_cfg_overlap;
      end else begin
        w_state_nxt = ST_CFG_ERR;
      end
    end else if (r_state == ST_ARMED && i_din_valid) begin
      w_hist_nxt = w_window;
      if (w_match && !r_ovl)             w_fill_nxt = '0;
      else if (w_fill_p1 >= {1'b0, r_len}) w_fill_nxt = r_len;
      else                                 w_fill_nxt = w_fill_p1[LEN_W-1:0];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_ARMED;
      r_pat   <= DEF_PATTERN;
      r_len   <= LEN_W'(DEF_LEN);
      r_ovl   <= DEF_OVERLAP;
      r_hist  <= '0;
      r_fill  <= '0;
      r_dout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_len   <= w_len_nxt;
      r_ovl   <= w_ovl_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_dout  <= w_match;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .i_clk (i_clock),
    .i_rst (i_reset),
    .i_inc (w_match),
    .i_clr (i_cfg_load),
    .o_q   (o_match_count)
  );

  assign o_dout    = r_dout;
  assign o_armed   = (r_state == ST_ARMED);
  assign o_cfg_err = (r_state == ST_CFG_ERR);

endmodule

// File: tb/tb_prog_seq_detector.sv
// Scoreboard bench: a queue-of-bits reference model predicts each cycle's outputs,
// a monitor pops and compares one cycle later.
module tb_prog_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               dout;
  logic [CNT_W-1:0]   match_count;
  logic               armed;
  logic               cfg_err;

  prog_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_cfg_load    (cfg_load),
    .i_cfg_pattern (cfg_pattern),
    .i_cfg_len     (cfg_len),
    .i_cfg_overlap (cfg_overlap),
    .i_din_valid   (din_valid),
    .i_din         (din),
    .o_dout        (dout),
    .o_match_count (match_count),
    .o_armed       (armed),
    .o_cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             dout;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   dut_pulses = 0;

  // Reference model: configuration plus the bits received since the last clear.
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  logic               m_ovl;
  logic               m_err;
  int                 m_cnt;
  logic               m_bits[$];

  function automatic void model_reset();
    m_pat = MAX_LEN'('b1011);
    m_len = 4;
    m_ovl = 1'b1;
    m_err = 1'b0;
    m_cnt = 0;
    m_bits.delete();
  endfunction

  function automatic exp_t model_step(input logic ld, input logic [MAX_LEN-1:0] pat,
                                      input int len, input logic ovl,
                                      input logic v, input logic d);
    exp_t e;
    logic hit;
    hit = 1'b0;
    if (ld) begin
      if (len >= 1 && len <= MAX_LEN) begin
        m_pat = pat; m_len = len; m_ovl = ovl; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_bits.delete();
      m_cnt = 0;
    end else if (!m_err && v) begin
      m_bits.push_back(d);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size()-1-i] != m_pat[i]) hit = 1'b0;
      end
      if (hit) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ovl) m_bits.delete();
      end
    end
    e.dout  = hit;
    e.cnt   = CNT_W'(m_cnt);
    e.armed = !m_err;
    e.err   = m_err;
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle, pushes the prediction at the next edge.
  task automatic drive(input logic ld, input logic [MAX_LEN-1:0] pat, input int len,
                       input logic ovl, input logic v, input logic d);
    exp_t e;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    din_valid   = v;
    din         = d;
    e = model_step(ld, pat, len, ovl, v, d);
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bits(input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b0, '0, 0, 1'b0, 1'b1, seq[i]);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input int len, input logic ovl);
    drive(1'b1, pat, len, ovl, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges, checks outputs clear without a clock edge.
  task automatic async_reset();
    #4;
    rst = 1'b1;
    #1;
    chk("rst_dout",  int'(dout), 0);
    chk("rst_count", int'(match_count), 0);
    chk("rst_armed", int'(armed), 1);
    chk("rst_err",   int'(cfg_err), 0);
    model_reset();
    cfg_load = 1'b0; din_valid = 1'b0; din = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulses_since(input string name, input int base, input int want);
    idle(2);
    #3;
    chk(name, dut_pulses - base, want);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #3;
    if (dout === 1'b1) dut_pulses++;
    if (sb.size() > 0) begin
      exp_t e;
      exp_t g;
      e = sb.pop_front();
      g = {dout, match_count, armed, cfg_err};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL scoreboard: got dout=%0b cnt=%0d armed=%0b err=%0b expected dout=%0b cnt=%0d armed=%0b err=%0b at %0t",
                 g.dout, g.cnt, g.armed, g.err, e.dout, e.cnt, e.armed, e.err, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int r;
    int len;
    rst = 1'b1;
    cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    din_valid = 1'b0; din = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("init_count", int'(match_count), 0);
    chk("init_armed", int'(armed), 1);
    chk("init_err",   int'(cfg_err), 0);
    chk("init_dout",  int'(dout), 0);
    rst = 1'b0;

    // Default 1011 overlapping: pulses after bits 4 and 7
    base = dut_pulses;
    bits(16'b1011011, 7);
    pulses_since("t1_pulses", base, 2);

    // Non-overlapping: single pulse
    base = dut_pulses;
    load(8'b1011, 4, 1'b0);
    bits(16'b1011011, 7);
    pulses_since("t2_pulses", base, 1);

    // Gaps in din_valid are transparent
    async_reset();
    base = dut_pulses;
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, '0, 0, 1'b0, 1'b1, (4'b1011 >> i) & 1'b1);
      if (i != 0) idle(3);
    end
    pulses_since("t3_pulses", base, 1);

    // Invalid length then recovery
    base = dut_pulses;
    load(8'b1011, 0, 1'b1);
    bits(16'b1011, 4);
    load(8'b111, 3, 1'b1);
    bits(16'b1111, 4);
    pulses_since("t4_pulses", base, 2);

    // len=1 with counter saturation
    base = dut_pulses;
    load(8'b1, 1, 1'b0);
    bits(16'b11111, 5);
    pulses_since("t5_pulses", base, 5);

    // Reset mid-stream discards partial history
    async_reset();
    base = dut_pulses;
    bits(16'b101, 3);
    async_reset();
    bits(16'b1, 1);
    bits(16'b011, 3);
    pulses_since("t6_pulses", base, 1);

    // Load coinciding with valid data: data dropped
    load(8'b1, 1, 1'b1);
    drive(1'b1, 8'b1, 1, 1'b1, 1'b1, 1'b1);
    bits(16'b1, 1);

    // Randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      len = 0;
      else if (r == 9) len = $urandom_range(9, 15);
      else             len = r;
      load(MAX_LEN'($urandom), len, 1'($urandom));
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(0, 39) == 0) begin
          r = $urandom_range(1, 8);
          drive(1'b1, MAX_LEN'($urandom), r, 1'($urandom), 1'($urandom), 1'($urandom));
        end else begin
          drive(1'b0, '0, 0, 1'b0, $urandom_range(0, 3) != 0, 1'($urandom));
        end
      end
      if ($urandom_range(0, 7) == 0) async_reset();
    end

    idle(2);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
